// File: rtl/mask_match_sequencer.sv
// Intersects weight/activation sparsity masks and streams the matched positions
// as beats of up to MAX_NUM_OUTPUT ascending indices, one block at a time.
module mask_match_sequencer #(
  parameter int BITMASK_LENGTH = 16,
  parameter int INDEX_BITWIDTH = 4,
  parameter int MAX_NUM_OUTPUT = 2
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     ivalid,
  output logic                                     oready,
  input  logic [BITMASK_LENGTH-1:0]                bitmaskW,
  input  logic [BITMASK_LENGTH-1:0]                bitmaskA,
  input  logic                                     isLast,
  output logic                                     ovalid,
  input  logic                                     iready,
  output logic [MAX_NUM_OUTPUT*INDEX_BITWIDTH-1:0] outIndices,
  output logic [1:0]                               outCount,
  output logic                                     outLast
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                                   state_q, state_d;
  logic [BITMASK_LENGTH-1:0]                mask_q, mask_d;
  logic                                     last_q, last_d;
  logic                                     ovalid_q, ovalid_d;
  logic [MAX_NUM_OUTPUT*INDEX_BITWIDTH-1:0] idx_q, idx_d;
  logic [1:0]                               cnt_q, cnt_d;
  logic                                     olast_q, olast_d;

  // stage[n] is the mask with its n lowest set bits already peeled off.
  logic [MAX_NUM_OUTPUT:0][BITMASK_LENGTH-1:0] stage;
  logic [MAX_NUM_OUTPUT-1:0]                   lane_hit;
  logic [MAX_NUM_OUTPUT*INDEX_BITWIDTH-1:0]    beat_idx;
  logic [1:0]                                  beat_cnt;
  logic [BITMASK_LENGTH-1:0]                   remaining;

  function automatic logic [INDEX_BITWIDTH-1:0] lowest_set(input logic [BITMASK_LENGTH-1:0] m);
    lowest_set = '0;
    for (int i = BITMASK_LENGTH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = INDEX_BITWIDTH'(i);
    end
  endfunction

  assign stage[0] = mask_q;

  generate
    for (genvar gi = 0; gi < MAX_NUM_OUTPUT; gi++) begin : g_lane
      assign lane_hit[gi]                                  = |stage[gi];
      assign stage[gi+1]                                   = stage[gi] & (stage[gi] - BITMASK_LENGTH'(1));
      assign beat_idx[gi*INDEX_BITWIDTH +: INDEX_BITWIDTH] = lane_hit[gi] ? lowest_set(stage[gi]) : '0;
    end
  endgenerate

  assign remaining = stage[MAX_NUM_OUTPUT];

  always_comb begin
    beat_cnt = '0;
    for (int l = 0; l < MAX_NUM_OUTPUT; l++) begin
      beat_cnt = beat_cnt + {1'b0, lane_hit[l]};
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    last_d   = last_q;
    ovalid_d = ovalid_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    olast_d  = olast_q;

    if (ovalid_q && iready) ovalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ivalid) begin
          mask_d  = bitmaskA & bitmaskW;
          last_d  = isLast;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Load only into an empty or currently draining output register.
        if (!ovalid_q || iready) begin
          ovalid_d = 1'b1;
          idx_d    = beat_idx;
          cnt_d    = beat_cnt;
          mask_d   = remaining;
          if (remaining == '0) begin
            olast_d = last_q;
            state_d = IDLE;
          end else begin
            olast_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      last_q   <= 1'b0;
      ovalid_q <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      olast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      last_q   <= last_d;
      ovalid_q <= ovalid_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      olast_q  <= olast_d;
    end
  end

  assign oready     = (state_q == IDLE) && !reset;
  assign ovalid     = ovalid_q;
  assign outIndices = idx_q;
  assign outCount   = cnt_q;
  assign outLast    = olast_q;

endmodule
